// File: rtl/uart_rx_pkg.sv
// Shared encodings and constants for the UART receiver: baud/parity selects,
// FSM states and small helper functions for divider and parity evaluation.
package uart_rx_pkg;

  localparam int OVERSAMPLE = 16;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  localparam logic [1:0] PAR_NONE     = 2'b00;
  localparam logic [1:0] PAR_ODD      = 2'b01;
  localparam logic [1:0] PAR_EVEN     = 2'b10;
  localparam logic [1:0] PAR_NONE_ALT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  function automatic int baud_hz(input logic [1:0] sel);
    case (sel)
      BAUD_2400: return 2400;
      BAUD_4800: return 4800;
      BAUD_9600: return 9600;
      default:   return 19200;
    endcase
  endfunction

  // Clock cycles per oversample tick; never below one so the counter always advances.
  function automatic int baud_div(input int clk_freq, input logic [1:0] sel);
    int d;
    d = clk_freq / (baud_hz(sel) * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic logic parity_en(input logic [1:0] ptype);
    return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
  endfunction

  function automatic logic parity_ok(input logic [7:0] data, input logic pbit,
                                     input logic [1:0] ptype);
    case (ptype)
      PAR_ODD:  return (^data) ^ pbit;
      PAR_EVEN: return ~((^data) ^ pbit);
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bus: serial line and configuration in, FIFO head and status out.
interface uart_rx_if;
  logic       rx;
  logic [1:0] baud_rate;
  logic [1:0] parity_type;
  logic       rd_en;
  logic [7:0] data_out;
  logic       fifo_emp;
  logic       fifo_full;
  logic       active;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rx, baud_rate, parity_type, rd_en,
    input  data_out, fifo_emp, fifo_full, active, parity_err, frame_err, overrun
  );

  modport slave (
    input  rx, baud_rate, parity_type, rd_en,
    output data_out, fifo_emp, fifo_full, active, parity_err, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx_baud_tick.sv
// Oversample tick generator: one-cycle pulse every CLK_FREQ/(baud*16) clocks,
// restarting whenever the baud selection changes.
module rx_baud_tick
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] baud_rate,
  output logic       tick
);
  localparam int DIV_MAX = baud_div(CLK_FREQ, BAUD_2400);
  localparam int CW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  localparam logic [CW-1:0] DIV0_M1 = CW'(baud_div(CLK_FREQ, BAUD_2400) - 1);
  localparam logic [CW-1:0] DIV1_M1 = CW'(baud_div(CLK_FREQ, BAUD_4800) - 1);
  localparam logic [CW-1:0] DIV2_M1 = CW'(baud_div(CLK_FREQ, BAUD_9600) - 1);
  localparam logic [CW-1:0] DIV3_M1 = CW'(baud_div(CLK_FREQ, BAUD_19200) - 1);

  logic [CW-1:0] cnt_q, cnt_d, div_m1_s;
  logic [1:0]    baud_q;
  logic          tick_q, tick_d;

  // Terminal count select and counter next-state.
  always_comb begin
    case (baud_rate)
      BAUD_2400: div_m1_s = DIV0_M1;
      BAUD_4800: div_m1_s = DIV1_M1;
      BAUD_9600: div_m1_s = DIV2_M1;
      default:   div_m1_s = DIV3_M1;
    endcase
    if (baud_rate != baud_q) begin
      cnt_d  = {CW{1'b0}};
      tick_d = 1'b0;
    end else if (cnt_q == div_m1_s) begin
      cnt_d  = {CW{1'b0}};
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + CW'(1);
      tick_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= {CW{1'b0}};
      baud_q <= 2'b00;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      baud_q <= baud_rate;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, 16x oversampling frame FSM with optional parity,
// and a first-word-fall-through receive FIFO with error/overrun pulses.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int DEPTH    = 16
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);
  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};

  logic          sync1_q, sync2_q, rx_prev_q, fall_s, tick_s;
  rx_state_e     state_q, state_d;
  logic [3:0]    tick_cnt_q, tick_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_bit_q, par_bit_d;
  logic          wr_s, do_wr_s, do_pop_s;
  logic          perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d, active_q, active_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next_s;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    dout_q, dout_d;
  logic          emp_q, emp_d, full_q, full_d;

  rx_baud_tick #(.CLK_FREQ(CLK_FREQ)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .baud_rate (bus.baud_rate),
    .tick      (tick_s)
  );

  assign fall_s = rx_prev_q & ~sync2_q;

  // Frame FSM next-state: samples land on tick 7 (start) and tick 15 thereafter.
  always_comb begin
    state_d = state_q;  tick_cnt_d = tick_cnt_q;  bit_cnt_d = bit_cnt_q;
    shift_d = shift_q;  par_bit_d  = par_bit_q;
    wr_s = 1'b0;  perr_d = 1'b0;  ferr_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall_s) begin
          state_d    = ST_START;
          tick_cnt_d = 4'd0;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s && tick_cnt_q == 4'd7) begin
          tick_cnt_d = 4'd0;
          bit_cnt_d  = 3'd0;
          state_d    = sync2_q ? ST_IDLE : ST_DATA;
        end else if (tick_s) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
      ST_DATA, ST_PARITY, ST_STOP: begin
        if (tick_s && tick_cnt_q == 4'd15) begin
          tick_cnt_d = 4'd0;
          if (state_q == ST_DATA) begin
            shift_d   = {sync2_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = parity_en(bus.parity_type) ? ST_PARITY : ST_STOP;
            end else begin
              state_d = ST_DATA;
            end
          end else if (state_q == ST_PARITY) begin
            par_bit_d = sync2_q;
            state_d   = ST_STOP;
          end else if (!sync2_q) begin
            // A bad stop bit outranks a parity mismatch.
            ferr_d  = 1'b1;
            state_d = ST_WAIT_IDLE;
          end else if (!parity_ok(shift_q, par_bit_q, bus.parity_type)) begin
            perr_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            wr_s    = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (tick_s) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
      ST_WAIT_IDLE: begin
        if (sync2_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    active_d = (state_d != ST_IDLE);
  end

  // FIFO next-state; the registered head tracks whichever byte will be at rd_ptr.
  always_comb begin
    do_pop_s  = bus.rd_en && (count_q != CNT_ZERO);
    do_wr_s   = wr_s && ((count_q != FULL_CNT) || do_pop_s);
    ovr_d     = wr_s && (count_q == FULL_CNT) && !do_pop_s;
    rd_next_s = rd_ptr_q + AW'(1);
    mem_d     = mem_q;
    if (do_wr_s) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d        = wr_ptr_q;
    end
    rd_ptr_d = do_pop_s ? rd_next_s : rd_ptr_q;
    if (do_wr_s && !do_pop_s) begin
      count_d = count_q + CNT_ONE;
    end else if (!do_wr_s && do_pop_s) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
    if (count_d == CNT_ZERO) begin
      dout_d = 8'h00;
    end else if (do_wr_s && ((count_q == CNT_ZERO) || (count_q == CNT_ONE && do_pop_s))) begin
      dout_d = shift_q;
    end else if (do_pop_s) begin
      dout_d = mem_q[rd_next_s];
    end else begin
      dout_d = dout_q;
    end
    emp_d  = (count_d == CNT_ZERO);
    full_d = (count_d == FULL_CNT);
  end

  // All state registers; synchronizer flops reset to the idle-high line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;  sync2_q <= 1'b1;  rx_prev_q <= 1'b1;
      state_q <= ST_IDLE;  tick_cnt_q <= 4'd0;  bit_cnt_q <= 3'd0;
      shift_q <= 8'h00;  par_bit_q <= 1'b0;
      perr_q <= 1'b0;  ferr_q <= 1'b0;  ovr_q <= 1'b0;  active_q <= 1'b0;
      mem_q <= '{default: 8'h00};
      wr_ptr_q <= {AW{1'b0}};  rd_ptr_q <= {AW{1'b0}};  count_q <= CNT_ZERO;
      dout_q <= 8'h00;  emp_q <= 1'b1;  full_q <= 1'b0;
    end else begin
      sync1_q <= bus.rx;  sync2_q <= sync1_q;  rx_prev_q <= sync2_q;
      state_q <= state_d;  tick_cnt_q <= tick_cnt_d;  bit_cnt_q <= bit_cnt_d;
      shift_q <= shift_d;  par_bit_q <= par_bit_d;
      perr_q <= perr_d;  ferr_q <= ferr_d;  ovr_q <= ovr_d;  active_q <= active_d;
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;  rd_ptr_q <= rd_ptr_d;  count_q <= count_d;
      dout_q <= dout_d;  emp_q <= emp_d;  full_q <= full_d;
    end
  end

  assign bus.data_out   = dout_q;
  assign bus.fifo_emp   = emp_q;
  assign bus.fifo_full  = full_q;
  assign bus.active     = active_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter DEPTH, default 16, receive FIFO depth in bytes (power of two).
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx  input  1  serial line, asynchronous to clk, idle high.
REQ-006 baud_rate  input  2  00=2400, 01=4800, 10=9600, 11=19200.
REQ-007 parity_type  input  2  00=none, 01=odd, 10=even, 11=none.
REQ-008 rd_en  input  1  pop the FIFO head.
REQ-009 data_out  output  8  FIFO head byte, valid while fifo_emp=0.
REQ-010 fifo_emp  output  1  FIFO empty.
REQ-011 fifo_full  output  1  FIFO holds DEPTH bytes.
REQ-012 active  output  1  frame reception in progress.
REQ-013 parity_err, frame_err, overrun  output  1 each  one-cycle error pulses.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-015 Oversample tick SHALL pulse once every DIV = CLK_FREQ/(baud*16) clk cycles (integer truncation); the divider restarts on any baud_rate change.
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-017 IDLE -> START on synchronized rx falling edge; the tick counter clears to 0.
REQ-018 START: at tick count 7, rx=0 -> DATA; rx=1 -> IDLE (glitch rejected, no error).
REQ-019 DATA: 8 bits, each sampled at tick 15 after the previous sample, LSB first into a shift register.
REQ-020 After bit 7: parity_type 01/10 -> PARITY, otherwise -> STOP.
REQ-021 PARITY: sample one bit; odd parity requires XOR(data, parity bit)=1, even requires it to equal 0.
REQ-022 STOP: sample one bit; rx=1 with parity OK -> write byte to FIFO, then IDLE.
REQ-023 Stop bit 0 -> frame_err pulse, byte discarded, -> WAIT_IDLE; WAIT_IDLE -> IDLE once rx=1.
REQ-024 Parity mismatch with a valid stop bit -> parity_err pulse, byte discarded, -> IDLE; if both fail, only frame_err pulses.
REQ-025 Byte write while FIFO is full and rd_en=0 -> byte dropped, overrun pulse; FIFO contents unchanged.
REQ-026 Write while full with rd_en=1 in the same cycle -> both occur, FIFO stays full, no overrun.
REQ-027 rd_en while empty is ignored; pointers unchanged.
REQ-028 data_out is first-word-fall-through: the head byte is visible the cycle after its write, and the next byte is visible the cycle after a pop.
REQ-029 FIFO pointers wrap modulo DEPTH; count is 0..DEPTH.
REQ-030 active=1 in every state except IDLE.
REQ-031 Error pulses are asserted in the cycle the STOP sample is taken.
REQ-032 baud_rate/parity_type changes mid-frame are unsupported; the receiver SHALL recover at the next IDLE.

Reset
REQ-033 rst SHALL force: FSM=IDLE, all counters=0, synchronizer flops=1, FIFO empty, data_out=0, fifo_emp=1, fifo_full=0, active=0, all error pulses=0.
REQ-034 rst mid-frame SHALL abandon the partial byte; no FIFO write or error pulse occurs.

Structure
REQ-035 Shared package: baud select encodings, parity_type encodings, FSM state encoding, and the OVERSAMPLE=16 constant.
REQ-036 One sub-module, rx_baud_tick (DIV computation plus tick counter); the FSM, shifter and FIFO live in uart_rx.

Verification (CLK_FREQ=1_536_000, baud 10 -> DIV=10)
REQ-037 Frame 0xA5, parity none -> data_out=0xA5 and fifo_emp=0 after the stop sample; no errors.
REQ-038 Frame 0x3C, even parity, parity bit 1 -> parity_err pulse; fifo_emp stays 1.
REQ-039 Frame 0x55, stop bit 0 -> frame_err pulse, no write; then rx held high and 0x12 sent -> 0x12 received.
REQ-040 rx low for 40 clks then high -> active returns to 0; no write, no error.
REQ-041 17 frames sent, no reads -> fifo_full=1 after 16, overrun pulse on the 17th; 16 pops return the bytes in order.
REQ-042 rst asserted during bit 4 -> all outputs at reset values; the next full frame is received correctly.
